// File: rtl/route_reserve_allocator.sv
// Per-output route reservation for a wormhole router: each output port arbitrates
// head-flit requests round-robin and stays reserved until its owning input releases it.
module route_reserve_allocator #(
    parameter int PORTS         = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS-1:0]                 routeReserveRequestValid,
    input  logic [PORTS*REQUEST_WIDTH-1:0]   routeReserveRequest,
    input  logic [PORTS-1:0]                 routeRelease,
    output logic [PORTS-1:0]                 routeReserveStatus,
    output logic [PORTS-1:0]                 outputBusy,
    output logic [PORTS-1:0]                 inputHasRoute,
    output logic [PORTS*REQUEST_WIDTH-1:0]   inputSelect
);

    typedef enum logic {IDLE = 1'b0, RESERVED = 1'b1} state_t;

    state_t                                  state_q [PORTS];
    state_t                                  state_d [PORTS];
    logic [PORTS-1:0][REQUEST_WIDTH-1:0]     owner_q, owner_d;
    logic [PORTS-1:0][REQUEST_WIDTH-1:0]     rr_q, rr_d;
    logic [PORTS-1:0]                        status_q, status_d;
    logic [PORTS-1:0]                        has_q, has_d;

    always_comb begin
        owner_d  = owner_q;
        rr_d     = rr_q;
        status_d = '0;
        has_d    = '0;
        for (int j = 0; j < PORTS; j++) begin
            int   best;
            int   bestd;
            int   d;
            logic rel;
            state_d[j] = state_q[j];
            best  = -1;
            bestd = PORTS;
            d     = 0;
            rel   = 1'b0;
            if (state_q[j] == IDLE) begin
                // Winner is the eligible input closest to rr_q[j] going upward, mod PORTS.
                for (int i = 0; i < PORTS; i++) begin
                    d = i - int'(rr_q[j]);
                    if (d < 0) d = d + PORTS;
                    if (routeReserveRequestValid[i] && !has_q[i] &&
                        routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(j) &&
                        d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
                for (int i = 0; i < PORTS; i++) begin
                    if (best == i) begin
                        state_d[j]  = RESERVED;
                        owner_d[j]  = REQUEST_WIDTH'(i);
                        status_d[i] = 1'b1;
                    end
                end
            end else begin
                for (int i = 0; i < PORTS; i++)
                    if (owner_q[j] == REQUEST_WIDTH'(i) && routeRelease[i]) rel = 1'b1;
                if (rel) begin
                    state_d[j] = IDLE;
                    owner_d[j] = '0;
                    rr_d[j]    = (owner_q[j] == REQUEST_WIDTH'(PORTS-1)) ? '0 : owner_q[j] + 1'b1;
                end
            end
        end
        for (int j = 0; j < PORTS; j++)
            for (int i = 0; i < PORTS; i++)
                if (state_d[j] == RESERVED && owner_d[j] == REQUEST_WIDTH'(i)) has_d[i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < PORTS; j++) state_q[j] <= IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            status_q <= '0;
            has_q    <= '0;
        end else begin
            for (int j = 0; j < PORTS; j++) state_q[j] <= state_d[j];
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            status_q <= status_d;
            has_q    <= has_d;
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_busy
        assign outputBusy[j] = (state_q[j] == RESERVED);
    end

    assign routeReserveStatus = status_q;
    assign inputHasRoute      = has_q;
    assign inputSelect        = owner_q;

endmodule

// File: tb/tb_route_reserve_allocator.sv
// Bench for route_reserve_allocator: directed vector table, reset/hold sequences,
// then random traffic against an ownership-list reference model.
module tb_route_reserve_allocator;
    localparam int P  = 4;
    localparam int RW = 3;

    logic            clk, rst;
    logic [P-1:0]    vld, rel;
    logic [P*RW-1:0] req;
    logic [P-1:0]    st, bz, hr;
    logic [P*RW-1:0] sel;

    int checks = 0;
    int errors = 0;

    route_reserve_allocator #(.PORTS(P), .REQUEST_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .routeReserveRequestValid(vld),
        .routeReserveRequest(req),
        .routeRelease(rel),
        .routeReserveStatus(st),
        .outputBusy(bz),
        .inputHasRoute(hr),
        .inputSelect(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]    v;
        logic [P*RW-1:0] rq;
        logic [P-1:0]    rl;
        logic [P-1:0]    st, bz, hr;
        logic [P*RW-1:0] sel;
    } vec_t;

    vec_t tbl [14];

    // reference model: owner per output (-1 idle) and round-robin start per output
    int own [P];
    int rr  [P];
    logic [P-1:0] m_st;

    function automatic logic [P*RW-1:0] mkreq(int r0, int r1, int r2, int r3);
        logic [RW-1:0] a, b, c, e;
        a = RW'(r0); b = RW'(r1); c = RW'(r2); e = RW'(r3);
        return {e, c, b, a};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, logic [P-1:0] e_st, logic [P-1:0] e_bz,
                           logic [P-1:0] e_hr, logic [P*RW-1:0] e_sel);
        chk({nm, ".status"}, 32'(st), 32'(e_st));
        chk({nm, ".busy"},   32'(bz), 32'(e_bz));
        chk({nm, ".hasrt"},  32'(hr), 32'(e_hr));
        chk({nm, ".sel"},    32'(sel), 32'(e_sel));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int j = 0; j < P; j++) begin own[j] = -1; rr[j] = 0; end
        m_st = '0;
    endtask

    // One clock edge of the allocator rules, using the inputs currently driven.
    task automatic model_edge();
        int  nown [P];
        bit  owns [P];
        int  r;
        m_st = '0;
        for (int i = 0; i < P; i++) owns[i] = 0;
        for (int j = 0; j < P; j++) if (own[j] >= 0) owns[own[j]] = 1;
        for (int j = 0; j < P; j++) begin
            nown[j] = own[j];
            if (own[j] >= 0) begin
                if (rel[own[j]]) begin
                    nown[j] = -1;
                    rr[j]   = (own[j] + 1) % P;
                end
            end else begin
                for (int k = 0; k < P; k++) begin
                    int i;
                    i = (rr[j] + k) % P;
                    r = int'(req[i*RW +: RW]);
                    if (nown[j] < 0 && vld[i] && r == j && !owns[i]) begin
                        nown[j] = i;
                        m_st[i] = 1'b1;
                    end
                end
            end
        end
        for (int j = 0; j < P; j++) own[j] = nown[j];
    endtask

    task automatic model_check(string nm);
        logic [P-1:0]    e_bz, e_hr;
        logic [P*RW-1:0] e_sel;
        e_bz = '0; e_hr = '0; e_sel = '0;
        for (int j = 0; j < P; j++) if (own[j] >= 0) begin
            e_bz[j] = 1'b1;
            e_hr[own[j]] = 1'b1;
            e_sel[j*RW +: RW] = RW'(own[j]);
        end
        chk_all(nm, m_st, e_bz, e_hr, e_sel);
    endtask

    initial begin
        rst = 1'b1; vld = '0; req = '0; rel = '0;
        tbl[0]  = '{4'b0100, mkreq(0,0,1,0), 4'b0000, 4'b0100, 4'b0010, 4'b0100, 12'h010};
        tbl[1]  = '{4'b0100, mkreq(0,0,1,0), 4'b0000, 4'b0000, 4'b0010, 4'b0100, 12'h010};
        tbl[2]  = '{4'b1001, mkreq(2,0,1,2), 4'b0000, 4'b0001, 4'b0110, 4'b0101, 12'h010};
        tbl[3]  = '{4'b1001, mkreq(2,0,1,2), 4'b0001, 4'b0000, 4'b0010, 4'b0100, 12'h010};
        tbl[4]  = '{4'b1001, mkreq(2,0,1,2), 4'b0000, 4'b1000, 4'b0110, 4'b1100, 12'h0D0};
        tbl[5]  = '{4'b1001, mkreq(2,0,1,2), 4'b0000, 4'b0000, 4'b0110, 4'b1100, 12'h0D0};
        tbl[6]  = '{4'b0001, mkreq(2,0,0,0), 4'b1000, 4'b0000, 4'b0010, 4'b0100, 12'h010};
        tbl[7]  = '{4'b0001, mkreq(2,0,0,0), 4'b0000, 4'b0001, 4'b0110, 4'b0101, 12'h010};
        tbl[8]  = '{4'b0000, mkreq(0,0,0,0), 4'b1010, 4'b0000, 4'b0110, 4'b0101, 12'h010};
        tbl[9]  = '{4'b0000, mkreq(0,0,0,0), 4'b0101, 4'b0000, 4'b0000, 4'b0000, 12'h000};
        tbl[10] = '{4'b0111, mkreq(1,2,3,0), 4'b0000, 4'b0111, 4'b1110, 4'b0111, 12'h440};
        tbl[11] = '{4'b0000, mkreq(0,0,0,0), 4'b0111, 4'b0000, 4'b0000, 4'b0000, 12'h000};
        tbl[12] = '{4'b1000, mkreq(0,0,0,5), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'h000};
        tbl[13] = '{4'b1000, mkreq(0,0,0,5), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'h000};

        #12;
        chk_all("reset", '0, '0, '0, '0);
        rst = 1'b0;

        for (int n = 0; n < 14; n++) begin
            vld = tbl[n].v; req = tbl[n].rq; rel = tbl[n].rl;
            step();
            chk_all($sformatf("vec%0d", n), tbl[n].st, tbl[n].bz, tbl[n].hr, tbl[n].sel);
        end

        // input 1 holds its request well past the grant: one pulse only
        vld = 4'b0010; req = mkreq(0,0,0,0); rel = '0;
        step();
        chk_all("hold.grant", 4'b0010, 4'b0001, 4'b0010, 12'h001);
        for (int n = 0; n < 5; n++) begin
            step();
            chk_all($sformatf("hold%0d", n), 4'b0000, 4'b0001, 4'b0010, 12'h001);
        end

        // second reservation, then asynchronous reset between edges
        vld = 4'b1010; req = mkreq(0,0,0,2);
        step();
        chk_all("two_res", 4'b1000, 4'b0101, 4'b1010, 12'h0C1);
        #3 rst = 1'b1;
        #1;
        chk_all("async_rst", '0, '0, '0, '0);
        vld = '0; req = '0;
        step();
        #4 rst = 1'b0;
        vld = 4'b0100; req = mkreq(0,0,3,0);
        step();
        chk_all("post_rst", 4'b0100, 4'b1000, 4'b0100, 12'h400);

        // random traffic against the reference model
        rst = 1'b1; vld = '0; req = '0; rel = '0;
        #4 rst = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            vld = P'($urandom);
            rel = P'($urandom & $urandom);
            req = mkreq($urandom_range(0,5), $urandom_range(0,5),
                        $urandom_range(0,5), $urandom_range(0,5));
            model_edge();
            step();
            model_check($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/route_reserve_allocator.md
ROUTE_RESERVE_ALLOCATOR -- requirements
Module: route_reserve_allocator

Interface
REQ-001 Parameter PORTS, default 4: number of router ports; inputs and outputs indexed 0..PORTS-1.
REQ-002 Parameter REQUEST_WIDTH, default 2: width of one route request (output port index), SHALL be >= $clog2(PORTS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 routeReserveRequestValid  input  PORTS  bit i: input port i holds a pending head-flit route request.
REQ-006 routeReserveRequest  input  PORTS*REQUEST_WIDTH  slice i: requested output index for input i.
REQ-007 routeRelease  input  PORTS  bit i: input port i's control FSM has forwarded its tail flit; its route is released.
REQ-008 routeReserveStatus  output  PORTS  bit i: one-cycle grant pulse to input port i.
REQ-009 outputBusy  output  PORTS  bit j: output j currently reserved.
REQ-010 inputHasRoute  output  PORTS  bit i: input i currently owns an output.
REQ-011 inputSelect  output  PORTS*REQUEST_WIDTH  slice j: crossbar select, index of the input owning output j; 0 when output j idle.

Function
REQ-012 Each output j SHALL run an independent two-state FSM: IDLE, RESERVED.
REQ-013 Eligible requester of output j: routeReserveRequestValid[i]=1, request slice i == j, inputHasRoute[i]=0.
REQ-014 IDLE with >=1 eligible requester: at the clock edge, select one by round-robin starting at rrPtr[j] upward modulo PORTS; record owner; go RESERVED.
REQ-015 Grant latency: request sampled at edge k -> routeReserveStatus[owner]=1, outputBusy[j]=1, inputHasRoute[owner]=1, inputSelect slice j=owner, all registered, visible in the cycle following edge k.
REQ-016 routeReserveStatus[i] SHALL be high for exactly one cycle per grant, then return to 0 regardless of whether routeReserveRequestValid[i] is still high.
REQ-017 A still-high request from an input that already owns a route SHALL be masked by inputHasRoute; no second grant, no second pulse.
REQ-018 RESERVED: stay until routeRelease[owner]=1 sampled; then at that edge go IDLE, clear outputBusy[j], inputHasRoute[owner], inputSelect slice j, and set rrPtr[j] = (owner+1) mod PORTS.
REQ-019 Release and new request for the same output sampled at the same edge: output frees at that edge; new grant no earlier than the next edge (one idle cycle minimum).
REQ-020 Release and new request from the same input at the same edge: new request masked at that edge; evaluated from the next edge.
REQ-021 routeRelease[i] while inputHasRoute[i]=0: ignored, no state change.
REQ-022 Request slice value >= PORTS: never granted, no state change; request holds until withdrawn.
REQ-023 Different outputs SHALL grant in the same cycle independently; at most one grant per input per cycle (one request slice per input).
REQ-024 Request withdrawn before grant: no grant, rrPtr unchanged.
REQ-025 Each input owns at most one output at any time; each output has at most one owner.

Reset
REQ-026 rst=1 SHALL asynchronously force all FSMs to IDLE, all rrPtr to 0, and routeReserveStatus, outputBusy, inputHasRoute, inputSelect to 0.
REQ-027 Reset mid-reservation SHALL drop all ownership with no grant pulse emitted; first grant after deassertion follows REQ-015 from the first sampled edge.

Verification
REQ-028 PORTS=4; input 2 requests output 1 at edge 0 -> cycle 1: routeReserveStatus=4'b0100, outputBusy=4'b0010, inputSelect slice 1=2; cycle 2: routeReserveStatus=0, ownership held.
REQ-029 Inputs 0 and 3 request output 2 simultaneously, rrPtr[2]=0 -> input 0 granted; release input 0 -> rrPtr[2]=1; input 3 granted at following edge, input 0 re-request waits.
REQ-030 Input 1 owns output 0, holds request high 5 cycles after grant -> exactly one status pulse, inputHasRoute[1]=1 throughout.
REQ-031 Release by owner and new request from input 3 to same output at same edge -> outputBusy low one cycle, grant to input 3 next edge.
REQ-032 Inputs 0->out1, 1->out2, 2->out3 same edge -> three pulses same cycle, outputBusy=4'b1110; request slice 4'hF-style out-of-range (REQUEST_WIDTH=3, value 5) -> no grant.
REQ-033 rst asserted mid-cycle while two outputs RESERVED -> all outputs 0 immediately, no clock needed; post-reset request granted one edge after sampling.
